// File: rtl/psum_ofifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psum_ofifo_pkg
// Purpose  : Shared width derivations and the column-slice helper for the
//            partial-sum output FIFO.
// Contents : addr_w()  - pointer width for a given depth
//            lvl_w()   - occupancy/level width (0..DEPTH inclusive)
//            col_lsb() - bit offset of column i inside a packed row
// Revision : 1.0 - initial release
// ============================================================================
package psum_ofifo_pkg;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a completely full column (count == DEPTH) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int col_lsb(input int col, input int bw);
    return col * bw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psum_ofifo_if.sv
`default_nettype none
// ============================================================================
// Module   : psum_ofifo_if
// Purpose  : Bus bundle between the array columns / readout consumer (master)
//            and the partial-sum output FIFO (slave).
// Signals  : wr[COL], in[PSUM_BW*COL], rd, flush          master -> fifo
//            out[PSUM_BW*COL], o_valid, o_ready, o_full,
//            o_afull, o_level, o_overflow, o_underflow     fifo -> master
// Revision : 1.0 - initial release
// ============================================================================
interface psum_ofifo_if #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int DEPTH   = 64
);
  import psum_ofifo_pkg::*;

  localparam int c_lvl_w = lvl_w(DEPTH);

  logic [COL-1:0]         wr;
  logic [PSUM_BW*COL-1:0] in;
  logic                   rd;
  logic                   flush;
  logic [PSUM_BW*COL-1:0] out;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_full;
  logic                   o_afull;
  logic [c_lvl_w-1:0]     o_level;
  logic                   o_overflow;
  logic                   o_underflow;

  modport master (
    output wr, in, rd, flush,
    input  out, o_valid, o_ready, o_full, o_afull, o_level, o_overflow, o_underflow
  );

  modport slave (
    input  wr, in, rd, flush,
    output out, o_valid, o_ready, o_full, o_afull, o_level, o_overflow, o_underflow
  );

endinterface
`default_nettype wire

// File: rtl/psum_ofifo_col.sv
`default_nettype none
// ============================================================================
// Module   : psum_ofifo_col
// Purpose  : One column lane of the partial-sum FIFO: circular buffer with
//            write/read pointers and an occupancy counter.
// Ports    : clk, reset_n          clock, async active-low reset
//            push, pop, flush      accepted write / accepted pop / clear
//            wdata                 word to store on push
//            rdata                 word at the read pointer (combinational)
//            empty, full, count    occupancy status (from registered counter)
// Revision : 1.0 - initial release
// ============================================================================
module psum_ofifo_col
  import psum_ofifo_pkg::*;
#(
  parameter  int DEPTH    = 64,
  parameter  int PSUM_BW  = 16,
  localparam int c_addr_w = addr_w(DEPTH),
  localparam int c_lvl_w  = lvl_w(DEPTH)
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  input  wire logic               push,
  input  wire logic               pop,
  input  wire logic               flush,
  input  wire logic [PSUM_BW-1:0] wdata,
  output logic      [PSUM_BW-1:0] rdata,
  output logic                    empty,
  output logic                    full,
  output logic      [c_lvl_w-1:0] count
);

  logic [PSUM_BW-1:0]  r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0]  r_count;

  // Storage carries no reset; validity is tracked entirely by the counter.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly c_addr_w bits wide, so DEPTH-1 -> 0 wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (push && !pop) begin
        r_count <= r_count + c_lvl_w'(1);
      end else if (pop && !push) begin
        r_count <= r_count - c_lvl_w'(1);
      end
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == c_lvl_w'(DEPTH));
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/psum_ofifo.sv
`default_nettype none
// ============================================================================
// Module   : psum_ofifo
// Purpose  : Output FIFO between systolic-array columns and the SFU/readout
//            path. Columns push independently; the consumer pops one aligned
//            row (one word per column) per read, with a registered read port.
// Ports    : clk        single clock, rising edge
//            reset_n    asynchronous active-low reset
//            bus        psum_ofifo_if.slave: wr, in, rd, flush in;
//                       out, o_valid, o_ready, o_full, o_afull, o_level,
//                       o_overflow, o_underflow out
// Revision : 1.0 - initial release
// ============================================================================
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int COL      = 8,
  parameter int PSUM_BW  = 16,
  parameter int DEPTH    = 64,
  parameter int AFULL_TH = DEPTH - 4
) (
  input wire logic    clk,
  input wire logic    reset_n,
  psum_ofifo_if.slave bus
);

  localparam int c_lvl_w = lvl_w(DEPTH);

  logic [COL-1:0]         w_push;
  logic [COL-1:0]         w_full;
  logic [COL-1:0]         w_empty;
  logic [c_lvl_w-1:0]     w_count [COL];
  logic [PSUM_BW*COL-1:0] w_row;
  logic [c_lvl_w-1:0]     w_level;
  logic                   w_ready;
  logic                   w_rd_acc;
  logic                   w_ovf_req;
  logic                   w_unf_req;

  logic [PSUM_BW*COL-1:0] r_out;
  logic                   r_valid;
  logic                   r_overflow;
  logic                   r_underflow;

  // A row is available only when every column holds at least one word,
  // which is the same condition as the minimum occupancy being non-zero.
  assign w_ready  = ~(|w_empty);

  // Flush outranks both read and write in the same cycle.
  assign w_rd_acc = bus.rd & w_ready & ~bus.flush;

  // A full column can still take a word when a row pop frees a slot.
  assign w_push   = bus.wr & (~w_full | {COL{w_rd_acc}}) & {COL{~bus.flush}};

  assign w_ovf_req = |(bus.wr & w_full & {COL{~w_rd_acc}});
  assign w_unf_req = bus.rd & ~w_ready;

  generate
    for (genvar i = 0; i < COL; i++) begin : g_col
      psum_ofifo_col #(
        .DEPTH   (DEPTH),
        .PSUM_BW (PSUM_BW)
      ) u_col (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push[i]),
        .pop     (w_rd_acc),
        .flush   (bus.flush),
        .wdata   (bus.in[col_lsb(i, PSUM_BW) +: PSUM_BW]),
        .rdata   (w_row[col_lsb(i, PSUM_BW) +: PSUM_BW]),
        .empty   (w_empty[i]),
        .full    (w_full[i]),
        .count   (w_count[i])
      );
    end
  endgenerate

  // Complete rows stored = smallest column occupancy.
  always_comb begin
    w_level = w_count[0];
    for (int i = 1; i < COL; i++) begin
      if (w_count[i] < w_level) begin
        w_level = w_count[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out       <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      // Read data register is intentionally left as-is; o_valid gates it.
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_out <= w_row;
      end
      if (w_ovf_req) begin
        r_overflow <= 1'b1;
      end
      if (w_unf_req) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.out         = r_out;
  assign bus.o_valid     = r_valid;
  assign bus.o_ready     = w_ready;
  assign bus.o_full      = |w_full;
  assign bus.o_afull     = (w_level >= c_lvl_w'(AFULL_TH));
  assign bus.o_level     = w_level;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_underflow = r_underflow;

endmodule
`default_nettype wire
